// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage. Holds the fetch PC, issues in-order word requests
//   to instruction memory, buffers returned words in a small FIFO and presents
//   {instruction, pc} pairs to decode with a valid/ready handshake. A redirect
//   reloads the PC, flushes the buffer and drops responses still in flight.
//
// Parameters
//   DATA_WIDTH  width of PC / addresses
//   RESET_PC    PC loaded at reset
//   FIFO_DEPTH  buffer entries, also the maximum number of outstanding requests
//
// Ports
//   clk, rstn                     clock, synchronous active-low reset
//   redirect_valid, redirect_pc   flush and restart fetch (pc bits [1:0] ignored)
//   imem_req, imem_addr           request to instruction memory
//   imem_ready                    memory accepts the request this cycle
//   imem_rvalid, imem_rdata       in-order read response
//   if_valid, if_instruction,
//   if_pc                         buffer head presented to decode
//   id_ready                      decode consumes the head this cycle
//
// Optional feature (macro IFU_PERF_CNT_EN)
//   perf_fetch_cnt    saturating count of words pushed into the buffer
//   perf_discard_cnt  saturating count of dropped responses
module instr_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata,
   output logic                  if_valid,
   output logic [31:0]           if_instruction,
   output logic [DATA_WIDTH-1:0] if_pc,
   input  logic                  id_ready
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_discard_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW:0]           DEPTH_C   = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]         FULL_C    = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0]         LAST_C    = PW'(FIFO_DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] resp_pc;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         discard;
   logic [CW-1:0]         count;
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [31:0]           buf_ins [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] buf_pc  [FIFO_DEPTH];

   logic [CW:0] credit_used;
   logic        accept;
   logic        rsp;
   logic        push;
   logic        drop;
   logic        pop;
   logic        unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   // Outstanding requests and buffered words share one credit pool, so every
   // response is guaranteed a free buffer slot.
   assign credit_used = {1'b0, outstanding} + {1'b0, count};
   assign imem_req    = rstn & ~redirect_valid & (credit_used < DEPTH_C);
   assign imem_addr   = pc_q;
   assign accept      = imem_req & imem_ready;

   // A response with nothing outstanding is a protocol violation and ignored.
   assign rsp  = imem_rvalid & (outstanding != '0);
   // Responses arriving in a redirect cycle belong to the old path.
   assign push = rsp & ~redirect_valid & (discard == '0);
   assign drop = rsp & ~push;

   assign if_valid       = rstn & (count != '0);
   assign if_instruction = buf_ins[head];
   assign if_pc          = buf_pc[head];
   assign pop            = if_valid & id_ready;

   assign unused_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q        <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         outstanding <= outstanding + CW'(accept) - CW'(rsp);
         if (redirect_valid) begin
            pc_q    <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            resp_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            discard <= outstanding - CW'(rsp);
            count   <= '0;
            head    <= '0;
            tail    <= '0;
         end else begin
            if (accept) pc_q <= pc_q + WORD_STEP;
            if (drop) discard <= discard - 1'b1;
            if (push) begin
               resp_pc <= resp_pc + WORD_STEP;
               tail    <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && push) begin
         buf_ins[tail] <= imem_rdata;
         buf_pc[tail]  <= resp_pc;
      end
   end

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_fetch_cnt   <= '0;
         perf_discard_cnt <= '0;
      end else begin
         if (push && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
         if (drop && (perf_discard_cnt != '1)) perf_discard_cnt <= perf_discard_cnt + 1'b1;
      end
   end
`endif

   no_overflow : assert property (@(posedge clk) disable iff (!rstn)
                                  !(push && (count == FULL_C)));

endmodule
